sim_run_monitor: RTL and testbench

SIM_RUN_MONITOR -- requirements
Module: sim_run_monitor

---
 rtl/sim_run_monitor.sv | 119 +++++++++++
 tb/tb_sim_run_monitor.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_run_monitor.sv
// Simulation run monitor: pulses the DUT reset, watches DUT memory writes against
// an ordered list of expected address/data pairs and reports pass, fail or timeout.
//
// state | meaning
// RST   | holding dut_reset high for RESET_CYCLES clocks
// RUN   | counting cycles, matching writes in order
// PASS  | every expected write seen (terminal)
// FAIL  | non-matching write with STRICT=1 (terminal)
// TMO   | TIMEOUT run cycles elapsed (terminal)
module sim_run_monitor #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int NUM_CHECKS   = 1,
    parameter logic [NUM_CHECKS*ADDR_W-1:0] EXP_ADDR = (NUM_CHECKS*ADDR_W)'(84),
    parameter logic [NUM_CHECKS*DATA_W-1:0] EXP_DATA = (NUM_CHECKS*DATA_W)'(7),
    parameter int RESET_CYCLES = 1,
    parameter int TIMEOUT      = 63,
    parameter int CNT_W        = 16,
    parameter int STRICT       = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] writedata,
    output logic              dut_reset,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [4:0]        check_idx,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  write_count
);

    typedef enum logic [2:0] {
        S_RST  = 3'd0,
        S_RUN  = 3'd1,
        S_PASS = 3'd2,
        S_FAIL = 3'd3,
        S_TMO  = 3'd4
    } state_t;

    state_t            state;
    logic [7:0]        rst_cnt;
    logic [ADDR_W-1:0] exp_adr;
    logic [DATA_W-1:0] exp_dat;
    logic              hit;
    logic              miss;
    logic              last;
    logic              at_limit;

    // Slot select by loop keeps the index in range once check_idx reaches NUM_CHECKS.
    always_comb begin
        exp_adr = '0;
        exp_dat = '0;
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if (check_idx == 5'(k)) begin
                exp_adr = EXP_ADDR[k*ADDR_W +: ADDR_W];
                exp_dat = EXP_DATA[k*DATA_W +: DATA_W];
            end
        end
    end

    assign hit      = memwrite && (adr == exp_adr) && (writedata == exp_dat);
    assign miss     = memwrite && !hit;
    assign last     = (check_idx == 5'(NUM_CHECKS - 1));
    assign at_limit = (cycle_count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RST;
            rst_cnt     <= 8'(RESET_CYCLES - 1);
            dut_reset   <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            check_idx   <= '0;
            cycle_count <= '0;
            write_count <= '0;
        end else begin
            case (state)
                S_RST: begin
                    if (rst_cnt == 8'd0) begin
                        state     <= S_RUN;
                        dut_reset <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt - 8'd1;
                    end
                end
                S_RUN: begin
                    if (cycle_count != '1)
                        cycle_count <= cycle_count + 1'b1;
                    if (memwrite && write_count != '1)
                        write_count <= write_count + 1'b1;
                    if (hit)
                        check_idx <= check_idx + 5'd1;
                    // Pass beats fail beats timeout when they land on the same cycle.
                    if (hit && last) begin
                        state <= S_PASS;
                        pass  <= 1'b1;
                        done  <= 1'b1;
                    end else if (miss && STRICT != 0) begin
                        state <= S_FAIL;
                        fail  <= 1'b1;
                        done  <= 1'b1;
                    end else if (at_limit) begin
                        state   <= S_TMO;
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_run_monitor.sv
// Directed bench for sim_run_monitor: four instances with different parameter sets
// sharing one clock, each driven by its own scenario tasks.
module tb_sim_run_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: defaults, 1: three checks non-strict, 2: strict, 3: RESET_CYCLES=3
    logic        rst   [4];
    logic        mw    [4];
    logic [31:0] adr   [4];
    logic [31:0] wd    [4];
    logic        dres  [4];
    logic        done  [4];
    logic        pass  [4];
    logic        fail  [4];
    logic        tmo   [4];
    logic [4:0]  idx   [4];
    logic [15:0] cyc   [4];
    logic [15:0] wcnt  [4];

    int compared   = 0;
    int mismatched = 0;

    sim_run_monitor u_def (
        .clk(clk), .reset(rst[0]), .memwrite(mw[0]), .adr(adr[0]), .writedata(wd[0]),
        .dut_reset(dres[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
        .timeout(tmo[0]), .check_idx(idx[0]), .cycle_count(cyc[0]), .write_count(wcnt[0])
    );

    sim_run_monitor #(
        .NUM_CHECKS(3),
        .EXP_ADDR({32'd92, 32'd88, 32'd84}),
        .EXP_DATA({32'd9, 32'd8, 32'd7}),
        .STRICT(0)
    ) u_multi (
        .clk(clk), .reset(rst[1]), .memwrite(mw[1]), .adr(adr[1]), .writedata(wd[1]),
        .dut_reset(dres[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
        .timeout(tmo[1]), .check_idx(idx[1]), .cycle_count(cyc[1]), .write_count(wcnt[1])
    );

    sim_run_monitor #(.STRICT(1)) u_strict (
        .clk(clk), .reset(rst[2]), .memwrite(mw[2]), .adr(adr[2]), .writedata(wd[2]),
        .dut_reset(dres[2]), .done(done[2]), .pass(pass[2]), .fail(fail[2]),
        .timeout(tmo[2]), .check_idx(idx[2]), .cycle_count(cyc[2]), .write_count(wcnt[2])
    );

    sim_run_monitor #(.RESET_CYCLES(3)) u_rst3 (
        .clk(clk), .reset(rst[3]), .memwrite(mw[3]), .adr(adr[3]), .writedata(wd[3]),
        .dut_reset(dres[3]), .done(done[3]), .pass(pass[3]), .fail(fail[3]),
        .timeout(tmo[3]), .check_idx(idx[3]), .cycle_count(cyc[3]), .write_count(wcnt[3])
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset instance i and wait (bounded) until it enters RUN at cycle 0.
    task automatic start_run(input int i);
        int guard;
        rst[i] = 1'b1;
        tick(1);
        rst[i] = 1'b0;
        guard = 0;
        do begin
            tick(1);
            guard++;
        end while (dres[i] !== 1'b0 && guard < 300);
        if (dres[i] !== 1'b0) begin
            compared++;
            mismatched++;
            $display("FAIL start_run[%0d]: dut_reset=%b, required 0 within 300 clocks", i, dres[i]);
        end
    endtask

    task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d);
        mw[i]  = 1'b1;
        adr[i] = a;
        wd[i]  = d;
        tick(1);
        mw[i]  = 1'b0;
    endtask

    task automatic test_reset();
        rst[0] = 1'b1;
        tick(2);
        compared++;
        if ({dres[0], done[0], pass[0], fail[0], tmo[0]} !== 5'b10000 ||
            idx[0] !== 5'd0 || cyc[0] !== 16'd0 || wcnt[0] !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_state: dres/done/pass/fail/tmo=%b%b%b%b%b idx=%0d cyc=%0d wc=%0d, required 10000 0 0 0",
                     dres[0], done[0], pass[0], fail[0], tmo[0], idx[0], cyc[0], wcnt[0]);
        end
        rst[0] = 1'b0;
        tick(1);
        compared++;
        if (dres[0] !== 1'b0 || cyc[0] !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_release: dut_reset=%b cyc=%0d, required 0 0", dres[0], cyc[0]);
        end
    endtask

    task automatic test_single_pass();
        start_run(0);
        tick(20);
        compared++;
        if (cyc[0] !== 16'd20 || done[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL single_pre: cyc=%0d done=%b, required 20 0", cyc[0], done[0]);
        end
        do_write(0, 32'd84, 32'd7);
        compared++;
        if (pass[0] !== 1'b1 || done[0] !== 1'b1 || cyc[0] !== 16'd21 || wcnt[0] !== 16'd1 || idx[0] !== 5'd1) begin
            mismatched++;
            $display("FAIL single_pass: pass=%b done=%b cyc=%0d wc=%0d idx=%0d, required 1 1 21 1 1",
                     pass[0], done[0], cyc[0], wcnt[0], idx[0]);
        end
        do_write(0, 32'd84, 32'd7);
        tick(3);
        compared++;
        if (pass[0] !== 1'b1 || cyc[0] !== 16'd21 || wcnt[0] !== 16'd1 || fail[0] !== 1'b0 || tmo[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL pass_frozen: pass=%b cyc=%0d wc=%0d fail=%b tmo=%b, required 1 21 1 0 0",
                     pass[0], cyc[0], wcnt[0], fail[0], tmo[0]);
        end
    endtask

    task automatic test_timeout();
        start_run(0);
        tick(62);
        compared++;
        if (tmo[0] !== 1'b0 || cyc[0] !== 16'd62) begin
            mismatched++;
            $display("FAIL timeout_pre: tmo=%b cyc=%0d, required 0 62", tmo[0], cyc[0]);
        end
        tick(1);
        compared++;
        if (tmo[0] !== 1'b1 || done[0] !== 1'b1 || pass[0] !== 1'b0 || cyc[0] !== 16'd63) begin
            mismatched++;
            $display("FAIL timeout_hit: tmo=%b done=%b pass=%b cyc=%0d, required 1 1 0 63",
                     tmo[0], done[0], pass[0], cyc[0]);
        end
        do_write(0, 32'd84, 32'd7);
        tick(2);
        compared++;
        if (tmo[0] !== 1'b1 || pass[0] !== 1'b0 || cyc[0] !== 16'd63 || wcnt[0] !== 16'd0) begin
            mismatched++;
            $display("FAIL timeout_frozen: tmo=%b pass=%b cyc=%0d wc=%0d, required 1 0 63 0",
                     tmo[0], pass[0], cyc[0], wcnt[0]);
        end
    endtask

    task automatic test_pass_at_limit();
        start_run(0);
        tick(62);
        do_write(0, 32'd84, 32'd7);
        compared++;
        if (pass[0] !== 1'b1 || tmo[0] !== 1'b0 || cyc[0] !== 16'd63) begin
            mismatched++;
            $display("FAIL pass_at_limit: pass=%b tmo=%b cyc=%0d, required 1 0 63", pass[0], tmo[0], cyc[0]);
        end
    endtask

    task automatic test_stray_nonstrict();
        logic [31:0] va [4] = '{32'd84, 32'd80, 32'd88, 32'd92};
        logic [31:0] vd [4] = '{32'd7, 32'd1, 32'd8, 32'd9};
        logic [4:0]  ei [4] = '{5'd1, 5'd1, 5'd2, 5'd3};
        start_run(1);
        tick(2);
        for (int k = 0; k < 4; k++) begin
            do_write(1, va[k], vd[k]);
            compared++;
            if (idx[1] !== ei[k] || fail[1] !== 1'b0 || pass[1] !== (k == 3)) begin
                mismatched++;
                $display("FAIL stray_step%0d: idx=%0d pass=%b fail=%b, required %0d %b 0",
                         k, idx[1], pass[1], fail[1], ei[k], (k == 3));
            end
        end
        compared++;
        if (wcnt[1] !== 16'd4 || done[1] !== 1'b1 || cyc[1] !== 16'd6) begin
            mismatched++;
            $display("FAIL stray_counts: wc=%0d done=%b cyc=%0d, required 4 1 6", wcnt[1], done[1], cyc[1]);
        end
    endtask

    task automatic test_strict();
        start_run(2);
        tick(1);
        do_write(2, 32'd84, 32'd6);
        compared++;
        if (fail[2] !== 1'b1 || done[2] !== 1'b1 || pass[2] !== 1'b0 || idx[2] !== 5'd0 || wcnt[2] !== 16'd1) begin
            mismatched++;
            $display("FAIL strict_data: fail=%b done=%b pass=%b idx=%0d wc=%0d, required 1 1 0 0 1",
                     fail[2], done[2], pass[2], idx[2], wcnt[2]);
        end
        start_run(2);
        do_write(2, 32'h0000_0154, 32'd7);
        compared++;
        if (fail[2] !== 1'b1 || pass[2] !== 1'b0) begin
            mismatched++;
            $display("FAIL strict_addr_high: fail=%b pass=%b, required 1 0", fail[2], pass[2]);
        end
        start_run(2);
        do_write(2, 32'd84, 32'd7);
        compared++;
        if (pass[2] !== 1'b1 || fail[2] !== 1'b0) begin
            mismatched++;
            $display("FAIL strict_match: pass=%b fail=%b, required 1 0", pass[2], fail[2]);
        end
    endtask

    task automatic test_mid_run_reset();
        logic [2:0] seen;
        start_run(3);
        tick(10);
        rst[3] = 1'b1;
        tick(1);
        compared++;
        if (dres[3] !== 1'b1 || cyc[3] !== 16'd0 || wcnt[3] !== 16'd0 || idx[3] !== 5'd0 || done[3] !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_clear: dres=%b cyc=%0d wc=%0d idx=%0d done=%b, required 1 0 0 0 0",
                     dres[3], cyc[3], wcnt[3], idx[3], done[3]);
        end
        rst[3] = 1'b0;
        mw[3]  = 1'b1;
        adr[3] = 32'd84;
        wd[3]  = 32'd7;
        seen   = '0;
        for (int k = 0; k < 3; k++) begin
            seen[k] = dres[3];
            tick(1);
        end
        mw[3] = 1'b0;
        compared++;
        if (seen !== 3'b111 || dres[3] !== 1'b0 || wcnt[3] !== 16'd0 || cyc[3] !== 16'd0 || pass[3] !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_pulse: dres_hist=%b dres=%b wc=%0d cyc=%0d pass=%b, required 111 0 0 0 0",
                     seen, dres[3], wcnt[3], cyc[3], pass[3]);
        end
        tick(5);
        do_write(3, 32'd84, 32'd7);
        compared++;
        if (pass[3] !== 1'b1 || cyc[3] !== 16'd6 || wcnt[3] !== 16'd1) begin
            mismatched++;
            $display("FAIL midreset_pass: pass=%b cyc=%0d wc=%0d, required 1 6 1", pass[3], cyc[3], wcnt[3]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1;
            mw[i]  = 1'b0;
            adr[i] = '0;
            wd[i]  = '0;
        end
        tick(2);
        for (int i = 1; i < 4; i++) rst[i] = 1'b0;
        test_reset();
        test_single_pass();
        test_timeout();
        test_pass_at_limit();
        test_stray_nonstrict();
        test_strict();
        test_mid_run_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
